// File: rtl/crypto_mon_pkg.sv
// Shared types and helpers for the crypto progress watchdog.
package crypto_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      STUCK = 2'd2
   } chan_state_t;

   // Increment v, saturating at the all-ones value of a w-bit field (w <= 64).
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
      logic [63:0] lim;
      lim = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      sat_inc = (v >= lim) ? lim : v + 64'd1;
   endfunction

endpackage

// File: rtl/crypto_progress_chan.sv
// One monitored channel: arm/progress FSM, latency counter, sticky error flags.
module crypto_progress_chan
   import crypto_mon_pkg::*;
#(
   parameter int unsigned CNT_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             arm,
   input  logic             progress,
   input  logic [CNT_W-1:0] timeout_cfg,
   input  logic             clr,
   output logic             busy,
   output logic             stuck,
   output logic             rearm_err,
   output logic             done,
   output logic [CNT_W-1:0] last_lat
);

   chan_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc, lat_nxt;
   logic             done_nxt, stuck_set, rearm_set;

   assign cnt_inc = CNT_W'(sat_inc(64'(cnt), CNT_W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         last_lat  <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         stuck     <= 1'b0;
         rearm_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         last_lat  <= lat_nxt;
         done      <= done_nxt;
         busy      <= (state_nxt == WAIT);
         stuck     <= (stuck & ~clr) | stuck_set;
         rearm_err <= (rearm_err & ~clr) | rearm_set;
      end
   end

   // Next state; progress beats timeout, arm with progress records then restarts.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      lat_nxt   = last_lat;
      done_nxt  = 1'b0;
      stuck_set = 1'b0;
      rearm_set = 1'b0;
      case (state)
         IDLE: begin
            if (arm) begin
               state_nxt = WAIT;
               cnt_nxt   = '0;
            end
         end
         WAIT: begin
            if (progress) begin
               lat_nxt  = cnt_inc;
               done_nxt = 1'b1;
               if (arm) cnt_nxt = '0;
               else     state_nxt = IDLE;
            end else if (arm) begin
               rearm_set = 1'b1;
               cnt_nxt   = '0;
            end else if (timeout_cfg != '0 && cnt_inc >= timeout_cfg) begin
               state_nxt = STUCK;
               stuck_set = 1'b1;
               cnt_nxt   = cnt_inc;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         STUCK: begin
            if (progress) lat_nxt = '1;
            if (arm) begin
               state_nxt = WAIT;
               cnt_nxt   = '0;
            end else if (progress) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/crypto_progress_watchdog.sv
// Multi-channel progress/timeout watchdog with cycle counter, heartbeat and irq.
module crypto_progress_watchdog
   import crypto_mon_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 24,
   parameter int unsigned CYC_W  = 32,
   parameter int unsigned HB_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       arm,
   input  logic [NUM_CH-1:0]       progress,
   input  logic [CNT_W-1:0]        timeout_cfg,
   input  logic [HB_W-1:0]         hb_period,
   input  logic [NUM_CH-1:0]       clr_stuck,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       stuck,
   output logic [NUM_CH-1:0]       rearm_err,
   output logic [NUM_CH-1:0]       done,
   output logic [NUM_CH*CNT_W-1:0] last_lat,
   output logic [CYC_W-1:0]        cycle_count,
   output logic                    heartbeat,
   output logic                    irq
);

   logic [HB_W-1:0] hb_cnt, hb_cnt_nxt, hb_last;

   // Heartbeat counter wraps at the live period; an oversized count drops to 0 silently.
   always_comb begin
      hb_last    = hb_period - HB_W'(1);
      hb_cnt_nxt = '0;
      if (hb_period != '0 && hb_cnt < hb_last) hb_cnt_nxt = hb_cnt + HB_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_count <= '0;
         hb_cnt      <= '0;
         heartbeat   <= 1'b0;
         irq         <= 1'b0;
      end else begin
         cycle_count <= CYC_W'(sat_inc(64'(cycle_count), CYC_W));
         hb_cnt      <= hb_cnt_nxt;
         heartbeat   <= (hb_period != '0) && (hb_cnt_nxt == hb_last);
         irq         <= (|stuck) | (|rearm_err);
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      crypto_progress_chan #(.CNT_W(CNT_W)) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .arm        (arm[i]),
         .progress   (progress[i]),
         .timeout_cfg(timeout_cfg),
         .clr        (clr_stuck[i]),
         .busy       (busy[i]),
         .stuck      (stuck[i]),
         .rearm_err  (rearm_err[i]),
         .done       (done[i]),
         .last_lat   (last_lat[i*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_crypto_progress_watchdog.sv
// Directed self-checking bench for crypto_progress_watchdog.
module tb_crypto_progress_watchdog;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CNT_W  = 24;
   localparam int unsigned CYC_W  = 32;
   localparam int unsigned HB_W   = 16;
   localparam logic [CNT_W-1:0] LAT_SAT = 24'hFF_FFFF;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NUM_CH-1:0]       arm, progress, clr_stuck;
   logic [CNT_W-1:0]        timeout_cfg;
   logic [HB_W-1:0]         hb_period;
   logic [NUM_CH-1:0]       busy, stuck, rearm_err, done;
   logic [NUM_CH*CNT_W-1:0] last_lat;
   logic [CYC_W-1:0]        cycle_count;
   logic                    heartbeat, irq;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   crypto_progress_watchdog #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CYC_W(CYC_W), .HB_W(HB_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .progress(progress),
      .timeout_cfg(timeout_cfg), .hb_period(hb_period), .clr_stuck(clr_stuck),
      .busy(busy), .stuck(stuck), .rearm_err(rearm_err), .done(done),
      .last_lat(last_lat), .cycle_count(cycle_count), .heartbeat(heartbeat), .irq(irq)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; arm = '0; progress = '0; clr_stuck = '0;
      timeout_cfg = 24'd20000; hb_period = 16'd5000;
      ticks(3);
      checks++;
      if ({busy, stuck, rearm_err, done, heartbeat, irq} !== '0) begin
         errors++;
         $display("FAIL reset_flags: got %0h expected 0", {busy, stuck, rearm_err, done, heartbeat, irq});
      end
      checks++;
      if (cycle_count !== '0) begin
         errors++;
         $display("FAIL reset_cycle: got %0d expected 0", cycle_count);
      end
      rst_n = 1'b1;
      arm = 4'b0001; tick(); arm = '0;
      ticks(50);
      checks++;
      if (busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL busy0_armed: got %b expected 1", busy[0]);
      end
      rst_n = 1'b0;
      ticks(3);
      rst_n = 1'b1;
      tick();
      checks++;
      if ({busy, stuck, last_lat} !== '0) begin
         errors++;
         $display("FAIL reset_midwait: got %0h expected 0", {busy, stuck, last_lat});
      end
      checks++;
      if (cycle_count !== 32'd1) begin
         errors++;
         $display("FAIL cycle_restart: got %0d expected 1", cycle_count);
      end
   endtask

   task automatic test_latency();
      timeout_cfg = 24'd20000;
      arm = 4'b0010; tick(); arm = '0;
      ticks(36);
      progress = 4'b0010; tick(); progress = '0;
      checks++;
      if (last_lat[1*CNT_W +: CNT_W] !== 24'd37) begin
         errors++;
         $display("FAIL lat1: got %0d expected 37", last_lat[1*CNT_W +: CNT_W]);
      end
      checks++;
      if (done !== 4'b0010 || busy[1] !== 1'b0) begin
         errors++;
         $display("FAIL done1: got done=%b busy=%b expected done=0010 busy=0", done, busy[1]);
      end
      tick();
      checks++;
      if (done !== 4'b0000 || irq !== 1'b0) begin
         errors++;
         $display("FAIL done1_once: got done=%b irq=%b expected 0000/0", done, irq);
      end
   endtask

   task automatic test_timeout();
      timeout_cfg = 24'd100;
      arm = 4'b0100; tick(); arm = '0;
      ticks(99);
      checks++;
      if (stuck[2] !== 1'b0) begin
         errors++;
         $display("FAIL stuck2_early: got %b expected 0", stuck[2]);
      end
      tick();
      checks++;
      if (stuck[2] !== 1'b1 || irq !== 1'b0) begin
         errors++;
         $display("FAIL stuck2_at100: got stuck=%b irq=%b expected 1/0", stuck[2], irq);
      end
      tick();
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_stuck2: got %b expected 1", irq);
      end
      ticks(48);
      progress = 4'b0100; tick(); progress = '0;
      checks++;
      if (last_lat[2*CNT_W +: CNT_W] !== LAT_SAT || done[2] !== 1'b0 || busy[2] !== 1'b0 || stuck[2] !== 1'b1) begin
         errors++;
         $display("FAIL late2: got lat=%0h done=%b busy=%b stuck=%b expected ffffff/0/0/1",
                  last_lat[2*CNT_W +: CNT_W], done[2], busy[2], stuck[2]);
      end
      clr_stuck = 4'b0100; tick(); clr_stuck = '0;
      checks++;
      if (stuck[2] !== 1'b0) begin
         errors++;
         $display("FAIL clr2: got %b expected 0", stuck[2]);
      end
      tick();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_clr: got %b expected 0", irq);
      end
   endtask

   task automatic test_boundary();
      timeout_cfg = 24'd10;
      arm = 4'b0100; tick(); arm = '0;
      ticks(9);
      progress = 4'b0100; tick(); progress = '0;
      checks++;
      if (done[2] !== 1'b1 || last_lat[2*CNT_W +: CNT_W] !== 24'd10 || stuck[2] !== 1'b0) begin
         errors++;
         $display("FAIL race10: got done=%b lat=%0d stuck=%b expected 1/10/0",
                  done[2], last_lat[2*CNT_W +: CNT_W], stuck[2]);
      end
      arm = 4'b0100; tick(); arm = '0;
      ticks(10);
      checks++;
      if (stuck[2] !== 1'b1) begin
         errors++;
         $display("FAIL race11_stuck: got %b expected 1", stuck[2]);
      end
      progress = 4'b0100; tick(); progress = '0;
      checks++;
      if (done[2] !== 1'b0 || last_lat[2*CNT_W +: CNT_W] !== LAT_SAT) begin
         errors++;
         $display("FAIL race11_late: got done=%b lat=%0h expected 0/ffffff", done[2], last_lat[2*CNT_W +: CNT_W]);
      end
      clr_stuck = 4'b0100; ticks(2); clr_stuck = '0;
      // Lowering the timeout below the running count forces STUCK at the next edge.
      timeout_cfg = 24'd20000;
      arm = 4'b0001; tick(); arm = '0;
      ticks(50);
      timeout_cfg = 24'd20;
      tick();
      checks++;
      if (stuck[0] !== 1'b1 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL lower_timeout: got stuck=%b busy=%b expected 1/0", stuck[0], busy[0]);
      end
      progress = 4'b0001; tick(); progress = '0;
      clr_stuck = 4'b0001; ticks(2); clr_stuck = '0;
   endtask

   task automatic test_rearm();
      timeout_cfg = 24'd20000;
      arm = 4'b1000; tick(); arm = '0;
      ticks(4);
      arm = 4'b1000; tick(); arm = '0;
      checks++;
      if (rearm_err[3] !== 1'b1 || busy[3] !== 1'b1 || done[3] !== 1'b0) begin
         errors++;
         $display("FAIL rearm3: got err=%b busy=%b done=%b expected 1/1/0", rearm_err[3], busy[3], done[3]);
      end
      clr_stuck = 4'b1000; tick(); clr_stuck = '0;
      checks++;
      if (rearm_err[3] !== 1'b0) begin
         errors++;
         $display("FAIL rearm3_clr: got %b expected 0", rearm_err[3]);
      end
      ticks(5);
      arm = 4'b1000; progress = 4'b1000; tick(); arm = '0; progress = '0;
      checks++;
      if (done[3] !== 1'b1 || last_lat[3*CNT_W +: CNT_W] !== 24'd7 || rearm_err[3] !== 1'b0 || busy[3] !== 1'b1) begin
         errors++;
         $display("FAIL arm_prog3: got done=%b lat=%0d err=%b busy=%b expected 1/7/0/1",
                  done[3], last_lat[3*CNT_W +: CNT_W], rearm_err[3], busy[3]);
      end
      ticks(2);
      progress = 4'b1000; tick(); progress = '0;
      checks++;
      if (last_lat[3*CNT_W +: CNT_W] !== 24'd3 || busy[3] !== 1'b0) begin
         errors++;
         $display("FAIL restart3: got lat=%0d busy=%b expected 3/0", last_lat[3*CNT_W +: CNT_W], busy[3]);
      end
      tick();
   endtask

   task automatic test_multi_channel();
      logic [NUM_CH*CNT_W-1:0] exp_lat;
      logic [NUM_CH-1:0]       exp_done;
      timeout_cfg = 24'd20000;
      arm = 4'b1111; tick(); arm = '0;
      for (int k = 1; k <= 40; k++) begin
         exp_done = {k == 40, k == 30, k == 20, k == 10};
         progress = exp_done;
         tick();
         progress = '0;
         if (exp_done != '0) begin
            checks++;
            if (done !== exp_done) begin
               errors++;
               $display("FAIL multi_done_%0d: got %b expected %b", k, done, exp_done);
            end
         end
      end
      exp_lat = {24'd40, 24'd30, 24'd20, 24'd10};
      checks++;
      if (last_lat !== exp_lat || busy !== '0) begin
         errors++;
         $display("FAIL multi_lat: got %0h busy=%b expected %0h busy=0", last_lat, busy, exp_lat);
      end
      timeout_cfg = '0;
      arm = 4'b0001; tick(); arm = '0;
      ticks(2000);
      checks++;
      if (stuck !== '0 || busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL no_timeout: got stuck=%b busy=%b expected 0000/1", stuck, busy[0]);
      end
      progress = 4'b0001; tick(); progress = '0;
   endtask

   task automatic test_heartbeat();
      int pulses;
      pulses = 0;
      for (int i = 0; i < 10000; i++) begin
         tick();
         if (heartbeat === 1'b1) begin
            pulses++;
            checks++;
            if (cycle_count % 5000 != 4999) begin
               errors++;
               $display("FAIL hb_phase: got pulse at cycle %0d expected cycle%%5000==4999", cycle_count);
            end
         end
      end
      checks++;
      if (pulses != 2) begin
         errors++;
         $display("FAIL hb_count: got %0d expected 2", pulses);
      end
      hb_period = 16'd1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (heartbeat !== 1'b1) begin
            errors++;
            $display("FAIL hb_period1_%0d: got %b expected 1", i, heartbeat);
         end
      end
      hb_period = '0;
      ticks(2);
      checks++;
      if (heartbeat !== 1'b0) begin
         errors++;
         $display("FAIL hb_disabled: got %b expected 0", heartbeat);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_timeout();
      test_boundary();
      test_rearm();
      test_multi_channel();
      test_heartbeat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
